fpga_config_loader: RTL and testbench

//  Receives the fabric configuration image as a stream of 32-bit words over a valid/ready link.

---
 rtl/fpga_config_loader.sv | 170 +++++++++++++++++
 tb/tb_fpga_config_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : fpga_config_loader
// Purpose  : Streams a checksummed configuration image into shadow registers
//            and commits it atomically to the live LUT / switch-box outputs.
// Revision : 1.0
// ============================================================================

module fpga_config_loader #(
  parameter int NUM_LUT = 8,
  parameter int NUM_SB  = 5,
  parameter int LUT_W   = 32,
  parameter int SB_W    = 16,
  parameter int DATA_W  = 32
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         word_valid,
  input  logic [DATA_W-1:0]            word_data,
  output logic                         word_ready,
  output logic [NUM_LUT*(LUT_W+1)-1:0] lut_mem,
  output logic [NUM_SB*SB_W-1:0]       sb_cfg,
  output logic                         busy,
  output logic                         cfg_done,
  output logic                         cfg_error
);

  localparam int c_n     = NUM_LUT + NUM_SB + 2;
  localparam int c_idx_w = $clog2(c_n);
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(c_n - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_idx_w-1:0]  r_idx;
  logic [DATA_W-1:0]   r_xor;
  logic                r_common;
  logic                w_xfer;
  logic                w_last;
  logic                w_match;
  logic                w_commit;

  // Ready drops combinationally during a start cycle so no word is consumed then.
  assign word_ready = (r_state == ST_LOAD) && !start;
  assign w_xfer     = word_valid && word_ready;
  assign w_last     = w_xfer && (r_idx == c_last);
  assign w_match    = (word_data == r_xor);

  assign busy       = (r_state == ST_LOAD);
  assign cfg_done   = (r_state == ST_DONE);
  assign cfg_error  = (r_state == ST_ERROR);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
        end else if (w_last) begin
          if (w_match) begin
            w_state_nxt = ST_DONE;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = ST_ERROR;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The running XOR covers every payload word bit, including ignored ones.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_idx <= '0;
      r_xor <= '0;
    end else if (start) begin
      r_idx <= '0;
      r_xor <= '0;
    end else if (w_xfer && !w_last) begin
      r_idx <= r_idx + c_idx_w'(1);
      r_xor <= r_xor ^ word_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_common <= 1'b0;
    end else if (w_xfer && (r_idx == '0)) begin
      r_common <= word_data[0];
    end
  end

  generate
    for (genvar i = 0; i < NUM_LUT; i++) begin : g_lut
      localparam logic [c_idx_w-1:0] c_sel = c_idx_w'(i + 1);
      logic [LUT_W-1:0] r_shadow;
      logic [LUT_W:0]   r_live;

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          r_shadow <= '0;
        end else if (w_xfer && (r_idx == c_sel)) begin
          r_shadow <= word_data[LUT_W-1:0];
        end
      end

      // Common bit is merged only at commit, so its arrival order is irrelevant.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          r_live <= '0;
        end else if (w_commit) begin
          r_live <= {r_common, r_shadow};
        end
      end

      assign lut_mem[i*(LUT_W+1) +: (LUT_W+1)] = r_live;
    end
  endgenerate

  generate
    for (genvar j = 0; j < NUM_SB; j++) begin : g_sb
      localparam logic [c_idx_w-1:0] c_sel = c_idx_w'(NUM_LUT + 1 + j);
      logic [SB_W-1:0] r_shadow;
      logic [SB_W-1:0] r_live;

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          r_shadow <= '0;
        end else if (w_xfer && (r_idx == c_sel)) begin
          r_shadow <= word_data[SB_W-1:0];
        end
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          r_live <= '0;
        end else if (w_commit) begin
          r_live <= r_shadow;
        end
      end

      assign sb_cfg[j*SB_W +: SB_W] = r_live;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fpga_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_config_loader
// Purpose  : Self-checking bench for fpga_config_loader against a queue-based
//            image model.
// Revision : 1.0
// ============================================================================

module tb_fpga_config_loader;

  localparam int NUM_LUT = 8;
  localparam int NUM_SB  = 5;
  localparam int LUT_W   = 32;
  localparam int SB_W    = 16;
  localparam int DATA_W  = 32;
  localparam int N       = NUM_LUT + NUM_SB + 2;
  localparam int LW      = NUM_LUT * (LUT_W + 1);
  localparam int SW      = NUM_SB * SB_W;

  logic              clock = 1'b0;
  logic              resetn;
  logic              start;
  logic              word_valid;
  logic [DATA_W-1:0] word_data;
  logic              word_ready;
  logic [LW-1:0]     lut_mem;
  logic [SW-1:0]     sb_cfg;
  logic              busy;
  logic              cfg_done;
  logic              cfg_error;

  fpga_config_loader #(
    .NUM_LUT (NUM_LUT),
    .NUM_SB  (NUM_SB),
    .LUT_W   (LUT_W),
    .SB_W    (SB_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .lut_mem    (lut_mem),
    .sb_cfg     (sb_cfg),
    .busy       (busy),
    .cfg_done   (cfg_done),
    .cfg_error  (cfg_error)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: accepted words of the current session, plus live state.
  bit                m_active;
  bit                m_done;
  bit                m_err;
  logic [DATA_W-1:0] m_words [$];
  logic [LW-1:0]     m_lut;
  logic [SW-1:0]     m_sb;

  typedef logic [DATA_W-1:0] image_t [N];

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_err    = 0;
    m_words.delete();
    m_lut    = '0;
    m_sb     = '0;
  endtask

  task automatic model_edge(input logic s, input logic v, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] x;
    if (s) begin
      m_active = 1;
      m_done   = 0;
      m_err    = 0;
      m_words.delete();
    end else if (m_active && v) begin
      m_words.push_back(d);
      if (m_words.size() == N) begin
        x = '0;
        for (int k = 0; k < N - 1; k++) x ^= m_words[k];
        if (x == m_words[N-1]) begin
          for (int i = 0; i < NUM_LUT; i++)
            m_lut[i*(LUT_W+1) +: (LUT_W+1)] = {m_words[0][0], m_words[1+i][LUT_W-1:0]};
          for (int j = 0; j < NUM_SB; j++)
            m_sb[j*SB_W +: SB_W] = m_words[1+NUM_LUT+j][SB_W-1:0];
          m_done = 1;
        end else begin
          m_err = 1;
        end
        m_active = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("busy",      busy,      m_active);
    check_eq("cfg_done",  cfg_done,  m_done);
    check_eq("cfg_error", cfg_error, m_err);
    check_eq("lut_mem",   lut_mem,   m_lut);
    check_eq("sb_cfg",    sb_cfg,    m_sb);
  endtask

  // One clock: drive inputs, check combinational ready, clock, check state.
  task automatic step(input logic s, input logic v, input logic [DATA_W-1:0] d);
    start      = s;
    word_valid = v;
    word_data  = d;
    #1;
    check_eq("word_ready", word_ready, m_active && !s);
    @(posedge clock);
    model_edge(s, v, d);
    #1;
    check_outputs();
  endtask

  task automatic async_reset();
    #2;
    resetn     = 1'b0;
    start      = 1'b0;
    word_valid = 1'b0;
    #1;
    model_reset();
    check_eq("rst_lut_mem",    lut_mem,    '0);
    check_eq("rst_sb_cfg",     sb_cfg,     '0);
    check_eq("rst_busy",       busy,       1'b0);
    check_eq("rst_cfg_done",   cfg_done,   1'b0);
    check_eq("rst_cfg_error",  cfg_error,  1'b0);
    check_eq("rst_word_ready", word_ready, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // gap: 0 none, 1 idle cycle after every word, 2 random idle cycles
  task automatic send_words(input image_t img, input int first, input int count, input int gap);
    for (int k = first; k < first + count; k++) begin
      if (gap == 2) begin
        while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, $urandom);
      end
      step(1'b0, 1'b1, img[k]);
      if (gap == 1) step(1'b0, 1'b0, $urandom);
    end
  endtask

  task automatic send_image(input image_t img, input int gap);
    step(1'b1, 1'b0, $urandom);
    send_words(img, 0, N, gap);
  endtask

  function automatic image_t make_random(input bit bad);
    image_t img;
    logic [DATA_W-1:0] x;
    x = '0;
    for (int k = 0; k < N - 1; k++) begin
      img[k] = $urandom;
      x ^= img[k];
    end
    img[N-1] = bad ? (x ^ (DATA_W'(1) << $urandom_range(0, DATA_W - 1))) : x;
    return img;
  endfunction

  function automatic image_t make_t2();
    image_t img;
    logic [DATA_W-1:0] x;
    img = '{32'h1, 32'hFFFF0000, 32'h0000FFFF, 32'hF0F0F0F0, 32'h0F0F0F0F,
            32'hAAAAAAAA, 32'h55555555, 32'h12345678, 32'h9ABCDEF0,
            32'h0003, 32'h000C, 32'h0030, 32'h00C0, 32'h0300, 32'h0};
    x = '0;
    for (int k = 0; k < N - 1; k++) x ^= img[k];
    img[N-1] = x;
    return img;
  endfunction

  initial begin
    image_t        t2;
    image_t        img;
    logic [LW-1:0] saved_lut;
    logic [SW-1:0] saved_sb;

    resetn     = 1'b0;
    start      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    model_reset();
    t2 = make_t2();
    repeat (2) @(posedge clock);
    #1;
    check_outputs();
    check_eq("rst_word_ready", word_ready, 1'b0);
    @(negedge clock);
    resetn = 1'b1;

    // Valid while idle must be ignored.
    repeat (3) step(1'b0, 1'b1, $urandom);

    // T2 good image
    send_image(t2, 0);
    check_eq("t2_lut0", lut_mem[LUT_W:0], {1'b1, 32'hFFFF0000});
    check_eq("t2_sb4",  sb_cfg[4*SB_W +: SB_W], 16'h0300);
    check_eq("t2_done", cfg_done, 1'b1);
    repeat (2) step(1'b0, 1'b1, $urandom);

    // T3 bad checksum keeps T2 live values
    saved_lut = lut_mem;
    saved_sb  = sb_cfg;
    send_image(make_random(1'b1), 2);
    check_eq("t3_err",  cfg_error, 1'b1);
    check_eq("t3_done", cfg_done,  1'b0);
    check_eq("t3_lut",  lut_mem,   saved_lut);
    check_eq("t3_sb",   sb_cfg,    saved_sb);

    // T4 alternate-cycle gaps
    send_image(make_random(1'b0), 0);
    send_image(t2, 1);
    check_eq("t4_lut", lut_mem, saved_lut);
    check_eq("t4_sb",  sb_cfg,  saved_sb);

    // T5 restart after 7 words
    img = make_random(1'b0);
    step(1'b1, 1'b0, '0);
    send_words(img, 0, 7, 0);
    img = make_random(1'b0);
    send_image(img, 0);
    check_eq("t5_sb0", sb_cfg[SB_W-1:0], img[NUM_LUT+1][SB_W-1:0]);

    // T6 reset mid-load, then a normal load
    step(1'b1, 1'b0, '0);
    send_words(t2, 0, 10, 0);
    async_reset();
    step(1'b0, 1'b0, '0);
    send_image(t2, 2);
    check_eq("t6_lut", lut_mem, saved_lut);

    // Randomised sessions: gaps, bad checksums, restarts, stray valids.
    for (int s = 0; s < 20; s++) begin
      img = make_random($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        step(1'b1, 1'b0, '0);
        send_words(make_random(1'b0), 0, $urandom_range(1, N - 1), 2);
      end
      send_image(img, 2);
      repeat ($urandom_range(0, 3)) step(1'b0, $urandom_range(0, 1) == 1, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
